// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the SDRAM controller between video, CPU and command engine, with periodic refresh.
// VRAM_ARB_ROUND_ROBIN_EN: cpu and cmd alternate priority instead of fixed cpu-over-cmd.
module vram_arbiter #(
  parameter int OP_CYCLES = 5,
  parameter int REFRESH_INTERVAL = 405
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        vid_req,
  input  logic [22:0] vid_addr,
  output logic        vid_ack,
  output logic [31:0] vid_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        cmd_req,
  input  logic        cmd_we,
  input  logic [1:0]  cmd_size,
  input  logic [22:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        cmd_ack,
  output logic [31:0] cmd_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic [7:0]  mem_din8,
  output logic [15:0] mem_din16,
  output logic [31:0] mem_din32,
  input  logic [15:0] mem_dout16,
  input  logic [31:0] mem_dout32,
  input  logic        mem_enabled,
  output logic        refresh_overrun
);
  typedef enum logic [2:0] {INIT, IDLE, CMD, WAIT, DONE} state_t;
  localparam int WW = $clog2(OP_CYCLES);
  localparam int RW = $clog2(REFRESH_INTERVAL);
  localparam logic [1:0] SRC_REF = 2'd0, SRC_VID = 2'd1, SRC_CPU = 2'd2, SRC_CMD = 2'd3;
  state_t state, state_n;
  logic [1:0] src, src_n, size_n, size_q;
  logic [22:0] addr_n;
  logic grant, we_n, we_q, a0_q, cpu_win, done, rd_done, expire, ref_grant;
  logic [WW-1:0] wcnt;
  logic [RW-1:0] rcnt;
  logic refresh_pending;
  logic [31:0] vid_q, cmd_q, cmd_live;
  logic [7:0] cpu_q, byte_sel;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
  logic cmd_first;
  assign cpu_win = cpu_req && !(cmd_req && cmd_first);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cmd_first <= 1'b0;
    else if (grant && src_n == SRC_CPU) cmd_first <= 1'b1;
    else if (grant && src_n == SRC_CMD) cmd_first <= 1'b0;
`else
  assign cpu_win = cpu_req;
`endif
  always_comb begin
    state_n = state;
    src_n = refresh_pending ? SRC_REF : vid_req ? SRC_VID : cpu_win ? SRC_CPU : SRC_CMD;
    grant = state == IDLE && (refresh_pending || vid_req || cpu_req || cmd_req);
    we_n = src_n == SRC_CPU ? cpu_we : src_n == SRC_CMD ? cmd_we : 1'b0;
    addr_n = src_n == SRC_VID ? vid_addr : src_n == SRC_CPU ? cpu_addr : cmd_addr;
    size_n = src_n == SRC_VID ? 2'b10 : src_n == SRC_CPU ? 2'b00 : cmd_size == 2'b11 ? 2'b01 : cmd_size;
    case (state)
      INIT: state_n = mem_enabled ? IDLE : INIT;
      IDLE: state_n = grant ? CMD : IDLE;
      CMD: state_n = WAIT;
      WAIT: state_n = wcnt == WW'(1) ? DONE : WAIT;
      DONE: state_n = IDLE;
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= INIT;
    else state <= state_n;
  assign done = state == DONE;
  assign rd_done = done && !we_q;
  assign expire = state != INIT && rcnt == '0;
  assign ref_grant = grant && src_n == SRC_REF;
  assign byte_sel = a0_q ? mem_dout16[15:8] : mem_dout16[7:0];
  assign cmd_live = size_q == 2'b10 ? mem_dout32 : size_q == 2'b01 ? {16'b0, mem_dout16} : {24'b0, byte_sel};
  assign vid_ack = done && src == SRC_VID;
  assign cpu_ack = done && src == SRC_CPU;
  assign cmd_ack = done && src == SRC_CMD;
  // Read data is presented live in the DONE cycle and held from the capture afterwards.
  assign vid_rdata = rd_done && src == SRC_VID ? mem_dout32 : vid_q;
  assign cpu_rdata = rd_done && src == SRC_CPU ? byte_sel : cpu_q;
  assign cmd_rdata = rd_done && src == SRC_CMD ? cmd_live : cmd_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_refresh <= 1'b0;
      mem_addr <= '0;
      mem_size <= '0;
      mem_din8 <= '0;
      mem_din16 <= '0;
      mem_din32 <= '0;
      refresh_overrun <= 1'b0;
      refresh_pending <= 1'b0;
      rcnt <= RW'(REFRESH_INTERVAL - 1);
      wcnt <= '0;
      src <= SRC_REF;
      we_q <= 1'b0;
      a0_q <= 1'b0;
      size_q <= '0;
      vid_q <= '0;
      cpu_q <= '0;
      cmd_q <= '0;
    end else begin
      mem_read <= grant && src_n != SRC_REF && !we_n;
      mem_write <= grant && src_n != SRC_REF && we_n;
      mem_refresh <= ref_grant;
      if (grant) begin
        src <= src_n;
        we_q <= we_n;
        a0_q <= addr_n[0];
        size_q <= size_n;
        mem_addr <= addr_n;
        mem_size <= size_n;
        mem_din8 <= src_n == SRC_CPU ? cpu_wdata : cmd_wdata[7:0];
      end
      if (grant && src_n == SRC_CMD) begin
        mem_din16 <= cmd_wdata[15:0];
        mem_din32 <= cmd_wdata;
      end
      wcnt <= state == CMD ? WW'(OP_CYCLES - 1) : state == WAIT ? wcnt - 1'b1 : wcnt;
      if (rd_done && src == SRC_VID) vid_q <= mem_dout32;
      if (rd_done && src == SRC_CPU) cpu_q <= byte_sel;
      if (rd_done && src == SRC_CMD) cmd_q <= cmd_live;
      if (state != INIT) rcnt <= rcnt == '0 ? RW'(REFRESH_INTERVAL - 1) : rcnt - 1'b1;
      // A new expiry wins over a same-cycle grant so no refresh is lost.
      refresh_pending <= expire || (refresh_pending && !ref_grant);
      if (expire && refresh_pending && !ref_grant) refresh_overrun <= 1'b1;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench; expectations queued at issue, monitor compares strobes and acks.
module tb_vram_arbiter;
  logic clk, resetn, mem_enabled;
  logic vid_req, vid_ack, cpu_req, cpu_we, cpu_ack, cmd_req, cmd_we, cmd_ack;
  logic [22:0] vid_addr, cpu_addr, cmd_addr, mem_addr;
  logic [31:0] vid_rdata, cmd_wdata, cmd_rdata, mem_din32, mem_dout32;
  logic [7:0] cpu_wdata, cpu_rdata, mem_din8;
  logic [1:0] cmd_size, mem_size;
  logic [15:0] mem_din16, mem_dout16;
  logic mem_read, mem_write, mem_refresh, refresh_overrun;
  logic x_resetn, x_vid_req;
  logic [1:0] x_vid_ack, x_cpu_ack, x_cmd_ack, x_rd, x_wr, x_ref, x_ovr;
  logic [31:0] x_vid_rdata [2];
  logic [31:0] x_cmd_rdata [2];
  logic [31:0] x_din32 [2];
  logic [7:0] x_cpu_rdata [2];
  logic [7:0] x_din8 [2];
  logic [22:0] x_addr [2];
  logic [1:0] x_size [2];
  logic [15:0] x_din16 [2];
  int cyc = 0, n_chk = 0, n_fail = 0, n_ack = 0;

  typedef struct packed {logic [15:0] c; logic [2:0] k; logic [1:0] sz; logic [22:0] a; logic [7:0] d8; logic [31:0] d32; logic [15:0] d16;} stb_t;
  typedef struct packed {logic m8; logic m32; stb_t s;} sq_t;
  typedef struct packed {logic [15:0] c; logic [1:0] p; logic [31:0] rd;} ack_t;
  typedef struct packed {logic mrd; ack_t a;} aq_t;
  sq_t sq[$];
  aq_t aq[$];

  vram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_size(cmd_size), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_din8(mem_din8), .mem_din16(mem_din16),
    .mem_din32(mem_din32), .mem_dout16(mem_dout16), .mem_dout32(mem_dout32),
    .mem_enabled(mem_enabled), .refresh_overrun(refresh_overrun)
  );

  for (genvar g = 0; g < 2; g++) begin : g_ref
    vram_arbiter #(.REFRESH_INTERVAL(g == 0 ? 20 : 3)) u (
      .clk(clk), .resetn(x_resetn),
      .vid_req(x_vid_req), .vid_addr(23'h000100), .vid_ack(x_vid_ack[g]), .vid_rdata(x_vid_rdata[g]),
      .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(23'h0), .cpu_wdata(8'h0),
      .cpu_ack(x_cpu_ack[g]), .cpu_rdata(x_cpu_rdata[g]),
      .cmd_req(1'b0), .cmd_we(1'b0), .cmd_size(2'b00), .cmd_addr(23'h0),
      .cmd_wdata(32'h0), .cmd_ack(x_cmd_ack[g]), .cmd_rdata(x_cmd_rdata[g]),
      .mem_read(x_rd[g]), .mem_write(x_wr[g]), .mem_refresh(x_ref[g]),
      .mem_addr(x_addr[g]), .mem_size(x_size[g]), .mem_din8(x_din8[g]), .mem_din16(x_din16[g]),
      .mem_din32(x_din32[g]), .mem_dout16(16'h0), .mem_dout32(32'h0),
      .mem_enabled(1'b1), .refresh_overrun(x_ovr[g])
    );
  end

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h expected %0h", n, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic es(input int dc, input logic [2:0] k, input logic [1:0] sz, input logic [22:0] a,
                    input logic m8, input logic [7:0] d8, input logic m32, input logic [31:0] d32);
    sq.push_back({m8, m32, 16'(cyc + dc), k, sz, a, m8 ? d8 : 8'h0, m32 ? d32 : 32'h0, m32 ? d32[15:0] : 16'h0});
  endtask

  task automatic ea(input int dc, input logic [1:0] p, input logic m, input logic [31:0] rd);
    aq.push_back({m, 16'(cyc + dc), p, m ? rd : 32'h0});
  endtask

  task automatic wait_acks(input int n, input logic drop);
    int got = 0;
    int t = 0;
    logic [2:0] a;
    while (got < n && t < 60) begin
      @(negedge clk);
      t++;
      a = {vid_ack, cpu_ack, cmd_ack};
      if (a != 3'b000) got++;
      step();
      if (drop && a[2]) vid_req = 0;
      if (drop && a[1]) cpu_req = 0;
      if (drop && a[0]) cmd_req = 0;
    end
    check("ack_timeout", got, n);
  endtask

  task automatic one(input int p, input logic we, input logic [1:0] sz, input logic [22:0] a,
                     input logic [31:0] wd, input logic [15:0] d16, input logic [31:0] d32,
                     input logic [1:0] esz, input logic [31:0] rd);
    mem_dout16 = d16;
    mem_dout32 = d32;
    if (p == 1) begin vid_addr = a; vid_req = 1; end
    else if (p == 2) begin cpu_we = we; cpu_addr = a; cpu_wdata = wd[7:0]; cpu_req = 1; end
    else begin cmd_we = we; cmd_size = sz; cmd_addr = a; cmd_wdata = wd; cmd_req = 1; end
    es(1, we ? 3'b010 : 3'b100, esz, a, we, wd[7:0], we && p == 3, wd);
    ea(6, 2'(p), !we, rd);
    wait_acks(1, 1);
  endtask

  always @(negedge clk) begin
    sq_t e;
    stb_t g;
    aq_t ee;
    ack_t ga;
    if (mem_read || mem_write || mem_refresh) begin
      if (sq.size() == 0) check("unexpected_strobe", 1, 0);
      else begin
        e = sq.pop_front();
        g = {16'(cyc), {mem_read, mem_write, mem_refresh}, mem_size, mem_addr,
             e.m8 ? mem_din8 : 8'h0, e.m32 ? mem_din32 : 32'h0, e.m32 ? mem_din16 : 16'h0};
        check("strobe", g, e.s);
      end
    end
    if (vid_ack || cpu_ack || cmd_ack) begin
      n_ack++;
      if (aq.size() == 0) check("unexpected_ack", 1, 0);
      else begin
        ee = aq.pop_front();
        ga.c = 16'(cyc);
        ga.p = vid_ack ? 2'd1 : cpu_ack ? 2'd2 : 2'd3;
        ga.rd = !ee.mrd ? 32'h0 : vid_ack ? vid_rdata : cpu_ack ? {24'h0, cpu_rdata} : cmd_rdata;
        check("ack", ga, ee.a);
      end
    end
  end

  initial begin
    int n0, r, c, fr, nr;
    resetn = 0; mem_enabled = 0; x_resetn = 0; x_vid_req = 0;
    vid_req = 0; cpu_req = 0; cmd_req = 0; cpu_we = 0; cmd_we = 0; cmd_size = 0;
    vid_addr = 0; cpu_addr = 0; cmd_addr = 0; cpu_wdata = 0; cmd_wdata = 0;
    mem_dout16 = 0; mem_dout32 = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", |{vid_ack, vid_rdata, cpu_ack, cpu_rdata, cmd_ack, cmd_rdata, mem_read, mem_write,
          mem_refresh, mem_addr, mem_size, mem_din8, mem_din16, mem_din32, refresh_overrun}, 0);
    step();
    resetn = 1;
    while (cyc < 4) step();
    vid_addr = 23'h000100; mem_dout32 = 32'hDEADBEEF; vid_req = 1;
    es(8, 3'b100, 2'b10, 23'h000100, 0, 0, 0, 0);
    ea(13, 2'd1, 1, 32'hDEADBEEF);
    while (cyc < 10) step();
    mem_enabled = 1;
    wait_acks(1, 1);
    one(2, 1, 0, 23'h000003, 32'h5A, 16'h0, 32'h0, 2'b00, 0);
    one(2, 0, 0, 23'h000003, 32'h0, 16'h5A00, 32'h0, 2'b00, 32'h5A);
    one(2, 0, 0, 23'h000002, 32'h0, 16'h12A5, 32'h0, 2'b00, 32'hA5);
    one(1, 0, 0, 23'h000104, 32'h0, 16'h0, 32'h13572468, 2'b10, 32'h13572468);
    one(3, 0, 2'b10, 23'h000010, 32'h0, 16'h1111, 32'hCAFEF00D, 2'b10, 32'hCAFEF00D);
    one(3, 0, 2'b01, 23'h000010, 32'h0, 16'hBEEF, 32'h99999999, 2'b01, 32'h0000BEEF);
    one(3, 0, 2'b11, 23'h000012, 32'h0, 16'h1234, 32'h99999999, 2'b01, 32'h00001234);
    one(3, 0, 2'b00, 23'h000013, 32'h0, 16'h7700, 32'h99999999, 2'b00, 32'h00000077);
    one(3, 1, 2'b10, 23'h000020, 32'h11223344, 16'h0, 32'h0, 2'b10, 0);
    vid_addr = 23'h000200; cpu_addr = 23'h000004; cpu_we = 0;
    cmd_addr = 23'h000030; cmd_size = 2'b01; cmd_we = 0;
    mem_dout32 = 32'h01020304; mem_dout16 = 16'h0506;
    vid_req = 1; cpu_req = 1; cmd_req = 1;
    es(1, 3'b100, 2'b10, 23'h000200, 0, 0, 0, 0);
    es(8, 3'b100, 2'b00, 23'h000004, 0, 0, 0, 0);
    es(15, 3'b100, 2'b01, 23'h000030, 0, 0, 0, 0);
    ea(6, 2'd1, 1, 32'h01020304);
    ea(13, 2'd2, 1, 32'h06);
    ea(20, 2'd3, 1, 32'h00000506);
    wait_acks(3, 1);
    cpu_addr = 23'h000005; cmd_addr = 23'h000040; cmd_size = 2'b10;
    mem_dout16 = 16'hC300; mem_dout32 = 32'h0BADF00D;
    cpu_req = 1; cmd_req = 1;
    es(1, 3'b100, 2'b00, 23'h000005, 0, 0, 0, 0);
    ea(6, 2'd2, 1, 32'hC3);
`ifdef VRAM_ARB_ROUND_ROBIN_EN
    es(8, 3'b100, 2'b10, 23'h000040, 0, 0, 0, 0);
    ea(13, 2'd3, 1, 32'h0BADF00D);
`else
    es(8, 3'b100, 2'b00, 23'h000005, 0, 0, 0, 0);
    ea(13, 2'd2, 1, 32'hC3);
`endif
    es(15, 3'b100, 2'b00, 23'h000005, 0, 0, 0, 0);
    ea(20, 2'd2, 1, 32'hC3);
    wait_acks(3, 0);
    cpu_req = 0; cmd_req = 0;
    n0 = n_ack;
    cmd_addr = 23'h000080; cmd_size = 2'b10; cmd_req = 1;
    es(1, 3'b100, 2'b10, 23'h000080, 0, 0, 0, 0);
    repeat (3) step();
    resetn = 0; mem_enabled = 0; cmd_req = 0;
    @(negedge clk);
    check("midop_reset_outputs", |{vid_ack, vid_rdata, cpu_ack, cpu_rdata, cmd_ack, cmd_rdata, mem_read, mem_write,
          mem_refresh, mem_addr, mem_size, mem_din8, mem_din16, mem_din32, refresh_overrun}, 0);
    step();
    resetn = 1;
    step();
    mem_enabled = 1; cmd_addr = 23'h000084; mem_dout32 = 32'h55AA55AA; cmd_req = 1;
    es(2, 3'b100, 2'b10, 23'h000084, 0, 0, 0, 0);
    ea(7, 2'd3, 1, 32'h55AA55AA);
    wait_acks(1, 1);
    check("acks_after_abandon", n_ack - n0, 1);
    check("strobe_queue_empty", sq.size(), 0);
    check("ack_queue_empty", aq.size(), 0);
    step();
    x_resetn = 1; x_vid_req = 1;
    r = cyc; fr = -1; nr = -1;
    repeat (40) begin
      @(negedge clk);
      c = cyc - r;
      if (x_ref[0] && fr < 0) fr = c;
      if (x_rd[0] && fr >= 0 && nr < 0) nr = c;
      if (c == 6) check("overrun_clear", x_ovr[1], 0);
      if (c == 7) check("overrun_set", x_ovr[1], 1);
    end
    check("refresh_cycle", fr, 23);
    check("vid_after_refresh", nr, 30);
    check("no_overrun_20", x_ovr[0], 0);
    x_vid_req = 0;
    repeat (20) step();
    check("overrun_sticky", x_ovr[1], 1);
    x_resetn = 0;
    #1;
    check("x_reset_outputs", |{x_vid_ack, x_cpu_ack, x_cmd_ack, x_rd, x_wr, x_ref, x_ovr,
          x_vid_rdata[0], x_vid_rdata[1], x_cmd_rdata[0], x_cmd_rdata[1], x_din32[0], x_din32[1],
          x_cpu_rdata[0], x_cpu_rdata[1], x_din8[0], x_din8[1], x_addr[0], x_addr[1],
          x_size[0], x_size[1], x_din16[0], x_din16[1]}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
